// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM core's block-transfer sequencer.
package arm_pkg;

    typedef enum logic [1:0] {IDLE, XFER, WBASE, EMPTY} seq_state_t;
    typedef enum logic [1:0] {IA, IB, DA, DB} addr_mode_t;

    localparam logic [3:0] PC_IDX = 4'd15;
    localparam int unsigned WORD_BYTES = 4;

    function automatic addr_mode_t decode_mode(input logic p, input logic u);
        addr_mode_t m;
        unique case ({p, u})
            2'b01:   m = IA;
            2'b11:   m = IB;
            2'b00:   m = DA;
            default: m = DB;
        endcase
        return m;
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/lowest_set16.sv
// Combinational priority encoder: index of the lowest set bit of a 16-bit vector.
module lowest_set16 (
    input  logic [15:0] vec,
    output logic [3:0]  idx,
    output logic        any
);

    always_comb begin
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) idx = 4'(i);
        end
    end

    assign any = |vec;

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer engine: moves one register per cycle between the
// register file and data memory, stalling the pipeline while busy.
module ldm_stm_sequencer #(
    parameter int unsigned WORD_BYTES = arm_pkg::WORD_BYTES,
    parameter int unsigned NREGS      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_load,
    input  logic             p_bit,
    input  logic             u_bit,
    input  logic             w_bit,
    input  logic [3:0]       base_reg,
    input  logic [31:0]      base_val,
    input  logic [NREGS-1:0] reg_list,
    input  logic [31:0]      rf_rd,
    input  logic [31:0]      mem_rdata,
    output logic             busy,
    output logic             done,
    output logic [3:0]       rf_ra,
    output logic [3:0]       rf_wa,
    output logic             rf_we,
    output logic [31:0]      rf_wd,
    output logic             pc_we,
    output logic [31:0]      pc_wd,
    output logic [31:0]      mem_addr,
    output logic             mem_we,
    output logic [31:0]      mem_wdata
);
    import arm_pkg::*;

    seq_state_t       state_q, state_d;
    logic [NREGS-1:0] pending_q, pending_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wb_val_q, wb_val_d;
    logic             is_load_q, is_load_d;
    logic             w_bit_q, w_bit_d;
    logic             base_listed_q, base_listed_d;
    logic [3:0]       base_reg_q, base_reg_d;

    logic [3:0]       cur;
    logic             any_set;
    logic [NREGS-1:0] rest;
    logic             last;
    logic             wbase_en;
    logic [4:0]       n;
    logic [31:0]      span;
    logic [31:0]      step;

    lowest_set16 u_lowest (
        .vec (pending_q),
        .idx (cur),
        .any (any_set)
    );

    assign rest     = pending_q & ~(NREGS'(1) << cur);
    assign last     = (rest == '0);
    // An LDM that reloads the base wins over the writeback value.
    assign wbase_en = w_bit_q && !(is_load_q && base_listed_q);
    assign n        = popcount16(reg_list);
    assign step     = 32'(WORD_BYTES);
    assign span     = 32'(n) * step;

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        addr_d        = addr_q;
        wb_val_d      = wb_val_q;
        is_load_d     = is_load_q;
        w_bit_d       = w_bit_q;
        base_listed_d = base_listed_q;
        base_reg_d    = base_reg_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pending_d     = reg_list;
                    is_load_d     = is_load;
                    w_bit_d       = w_bit;
                    base_reg_d    = base_reg;
                    base_listed_d = reg_list[base_reg];
                    wb_val_d      = u_bit ? base_val + span : base_val - span;
                    // All modes walk upward from the lowest address of the block.
                    unique case (decode_mode(p_bit, u_bit))
                        IA: addr_d = base_val;
                        IB: addr_d = base_val + step;
                        DA: addr_d = base_val - span + step;
                        DB: addr_d = base_val - span;
                    endcase
                    state_d = (reg_list == '0) ? EMPTY : XFER;
                end
            end
            XFER: begin
                pending_d = rest;
                addr_d    = addr_q + step;
                if (last) state_d = wbase_en ? WBASE : IDLE;
            end
            WBASE:   state_d = IDLE;
            EMPTY:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            addr_q        <= '0;
            wb_val_q      <= '0;
            is_load_q     <= 1'b0;
            w_bit_q       <= 1'b0;
            base_listed_q <= 1'b0;
            base_reg_q    <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            addr_q        <= addr_d;
            wb_val_q      <= wb_val_d;
            is_load_q     <= is_load_d;
            w_bit_q       <= w_bit_d;
            base_listed_q <= base_listed_d;
            base_reg_q    <= base_reg_d;
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        done      = 1'b0;
        rf_ra     = '0;
        rf_wa     = '0;
        rf_we     = 1'b0;
        rf_wd     = '0;
        pc_we     = 1'b0;
        pc_wd     = '0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        unique case (state_q)
            XFER: begin
                if (any_set) begin
                    mem_addr = addr_q;
                    done     = last && !wbase_en;
                    if (!is_load_q) begin
                        rf_ra     = cur;
                        mem_we    = 1'b1;
                        mem_wdata = rf_rd;
                    end else if (cur == PC_IDX) begin
                        pc_we = 1'b1;
                        pc_wd = mem_rdata;
                    end else begin
                        rf_we = 1'b1;
                        rf_wa = cur;
                        rf_wd = mem_rdata;
                    end
                end
            end
            WBASE: begin
                rf_we = 1'b1;
                rf_wa = base_reg_q;
                rf_wd = wb_val_q;
                done  = 1'b1;
            end
            EMPTY:   done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed table-driven bench for ldm_stm_sequencer plus a mid-transfer reset sequence.
module tb_ldm_stm_sequencer;

    typedef struct packed {
        logic        start;
        logic        is_load;
        logic        p;
        logic        u;
        logic        w;
        logic [3:0]  rn;
        logic [31:0] base;
        logic [15:0] list;
        logic [31:0] rf_rd;
        logic [31:0] mem_rdata;
    } in_t;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [3:0]  ra;
        logic [3:0]  wa;
        logic        rf_we;
        logic [31:0] rf_wd;
        logic        pc_we;
        logic [31:0] pc_wd;
        logic [31:0] mem_addr;
        logic        mem_we;
        logic [31:0] mem_wdata;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, is_load, p_bit, u_bit, w_bit;
    logic [3:0]  base_reg;
    logic [31:0] base_val;
    logic [15:0] reg_list;
    logic [31:0] rf_rd, mem_rdata;
    logic        busy, done, rf_we, pc_we, mem_we;
    logic [3:0]  rf_ra, rf_wa;
    logic [31:0] rf_wd, pc_wd, mem_addr, mem_wdata;

    int passed = 0;
    int total  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    ldm_stm_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_load   (is_load),
        .p_bit     (p_bit),
        .u_bit     (u_bit),
        .w_bit     (w_bit),
        .base_reg  (base_reg),
        .base_val  (base_val),
        .reg_list  (reg_list),
        .rf_rd     (rf_rd),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .rf_ra     (rf_ra),
        .rf_wa     (rf_wa),
        .rf_we     (rf_we),
        .rf_wd     (rf_wd),
        .pc_we     (pc_we),
        .pc_wd     (pc_wd),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata)
    );

    function automatic in_t go(input logic ld, input logic p, input logic u, input logic w,
                               input logic [3:0] rn, input logic [31:0] base,
                               input logic [15:0] list);
        in_t r;
        r = '0;
        r.start = 1'b1; r.is_load = ld; r.p = p; r.u = u; r.w = w;
        r.rn = rn; r.base = base; r.list = list;
        return r;
    endfunction

    function automatic in_t beat(input logic [31:0] rd, input logic [31:0] md);
        in_t r;
        r = '0;
        r.rf_rd = rd; r.mem_rdata = md;
        return r;
    endfunction

    function automatic out_t idle();
        return '0;
    endfunction

    function automatic out_t stm(input logic [3:0] ra, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic dn);
        out_t o;
        o = '0;
        o.busy = 1'b1; o.done = dn; o.ra = ra; o.mem_addr = addr;
        o.mem_we = 1'b1; o.mem_wdata = wdata;
        return o;
    endfunction

    function automatic out_t ldm(input logic [3:0] wa, input logic [31:0] addr,
                                 input logic [31:0] data, input logic dn);
        out_t o;
        o = '0;
        o.busy = 1'b1; o.done = dn; o.wa = wa; o.rf_we = 1'b1; o.rf_wd = data;
        o.mem_addr = addr;
        return o;
    endfunction

    function automatic out_t pcl(input logic [31:0] addr, input logic [31:0] data,
                                 input logic dn);
        out_t o;
        o = '0;
        o.busy = 1'b1; o.done = dn; o.pc_we = 1'b1; o.pc_wd = data; o.mem_addr = addr;
        return o;
    endfunction

    function automatic out_t wb(input logic [3:0] wa, input logic [31:0] wd);
        out_t o;
        o = '0;
        o.busy = 1'b1; o.done = 1'b1; o.wa = wa; o.rf_we = 1'b1; o.rf_wd = wd;
        return o;
    endfunction

    function automatic out_t empty();
        out_t o;
        o = '0;
        o.busy = 1'b1; o.done = 1'b1;
        return o;
    endfunction

    function automatic out_t cur_out();
        out_t o;
        o = '{busy, done, rf_ra, rf_wa, rf_we, rf_wd, pc_we, pc_wd, mem_addr, mem_we,
              mem_wdata};
        return o;
    endfunction

    task automatic drive(input in_t x);
        start = x.start; is_load = x.is_load; p_bit = x.p; u_bit = x.u; w_bit = x.w;
        base_reg = x.rn; base_val = x.base; reg_list = x.list;
        rf_rd = x.rf_rd; mem_rdata = x.mem_rdata;
    endtask

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = cur_out();
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: actual busy=%b done=%b ra=%h wa=%h rf_we=%b rf_wd=%h pc_we=%b pc_wd=%h addr=%h mem_we=%b wdata=%h | required busy=%b done=%b ra=%h wa=%h rf_we=%b rf_wd=%h pc_we=%b pc_wd=%h addr=%h mem_we=%b wdata=%h",
                     name, act.busy, act.done, act.ra, act.wa, act.rf_we, act.rf_wd,
                     act.pc_we, act.pc_wd, act.mem_addr, act.mem_we, act.mem_wdata,
                     exp.busy, exp.done, exp.ra, exp.wa, exp.rf_we, exp.rf_wd,
                     exp.pc_we, exp.pc_wd, exp.mem_addr, exp.mem_we, exp.mem_wdata);
        end
    endtask

    initial begin
        in_t tmp;

        // Row 0: idle after reset
        vecs.push_back('{beat(32'h0, 32'h0), idle()});
        // STM IA, base 0x100, {R1,R2,R3}, writeback into R0
        vecs.push_back('{go(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 32'h100, 16'h000E), idle()});
        vecs.push_back('{beat(32'hA1, 32'hDEAD), stm(4'd1, 32'h100, 32'hA1, 1'b0)});
        vecs.push_back('{beat(32'hA2, 32'hDEAD), stm(4'd2, 32'h104, 32'hA2, 1'b0)});
        vecs.push_back('{beat(32'hA3, 32'hDEAD), stm(4'd3, 32'h108, 32'hA3, 1'b0)});
        vecs.push_back('{beat(32'h0, 32'h0), wb(4'd0, 32'h10C)});
        // LDM DB, base 0x200, {R0,R1,R15}, no writeback
        vecs.push_back('{go(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 32'h200, 16'h8003), idle()});
        vecs.push_back('{beat(32'h0, 32'h11), ldm(4'd0, 32'h1F4, 32'h11, 1'b0)});
        vecs.push_back('{beat(32'h0, 32'h22), ldm(4'd1, 32'h1F8, 32'h22, 1'b0)});
        vecs.push_back('{beat(32'h0, 32'h8000), pcl(32'h1FC, 32'h8000, 1'b1)});
        // LDM IB into the base register: writeback suppressed
        vecs.push_back('{go(1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 32'h40, 16'h0004), idle()});
        vecs.push_back('{beat(32'h0, 32'h55), ldm(4'd2, 32'h44, 32'h55, 1'b1)});
        // Empty list
        vecs.push_back('{go(1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 32'h80, 16'h0000), idle()});
        vecs.push_back('{beat(32'h0, 32'h0), empty()});
        // STM DA, base R4 in list, writeback; start pulses while busy are ignored
        vecs.push_back('{go(1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 32'h300, 16'h0011), idle()});
        tmp = go(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 32'h0, 16'hFFFF);
        tmp.rf_rd = 32'h1000;
        vecs.push_back('{tmp, stm(4'd0, 32'h2FC, 32'h1000, 1'b0)});
        tmp.rf_rd = 32'h300;
        vecs.push_back('{tmp, stm(4'd4, 32'h300, 32'h300, 1'b0)});
        tmp.rf_rd = 32'h0;
        vecs.push_back('{tmp, wb(4'd4, 32'h2F8)});
        vecs.push_back('{beat(32'h0, 32'h0), idle()});

        reset = 1'b1;
        drive(beat(32'h0, 32'h0));
        #3;
        check("reset_state", idle());
        #9;
        reset = 1'b0;

        foreach (vecs[k]) begin
            @(posedge clk);
            #1 drive(vecs[k].i);
            #1 check($sformatf("row%0d", k), vecs[k].e);
        end

        // Reset asserted between edges in the middle of a 4-register STM
        @(posedge clk);
        #1 drive(go(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h500, 16'h00F0));
        @(posedge clk);
        #1 drive(beat(32'h77, 32'h0));
        #1 check("rst_seq_beat0", stm(4'd4, 32'h500, 32'h77, 1'b0));
        @(posedge clk);
        #2 check("rst_seq_beat1", stm(4'd5, 32'h504, 32'h77, 1'b0));
        #2 reset = 1'b1;
        #1 check("rst_async_clear", idle());
        @(posedge clk);
        #2 check("rst_held", idle());
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #2 check($sformatf("post_rst_quiet%0d", c), idle());
        end
        @(posedge clk);
        #1 drive(go(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h600, 16'h0001));
        @(posedge clk);
        #1 drive(beat(32'hCAFE, 32'h0));
        #1 check("post_rst_start", stm(4'd0, 32'h600, 32'hCAFE, 1'b1));
        @(posedge clk);
        #2 check("post_rst_idle", idle());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
Multi-cycle block-transfer engine for the pipelined ARM core; implements LDM/STM. It is the client of the register-file ports: it drives the read address and consumes read data for STM, and drives write address, enable and data for LDM. It transfers one word per cycle between the register file and data memory and holds the pipeline stalled through `busy`.

Parameters:
WORD_BYTES, 4, address increment per transferred register
NREGS, 16, width of the register list

Ports:
clk  in  1  core clock; all state updates on posedge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request, sampled at posedge; ignored while busy
is_load  in  1  1 = LDM, 0 = STM
p_bit  in  1  pre-index (1) / post-index (0)
u_bit  in  1  up (1) / down (0)
w_bit  in  1  base writeback enable
base_reg  in  4  base register number Rn
base_val  in  32  Rn value at start
reg_list  in  16  register list; bit i = Ri
rf_rd  in  32  register-file read data for rf_ra (R15 returns PC+8 from the file)
mem_rdata  in  32  data memory read data, combinational for mem_addr
busy  out  1  stall request to hazard unit
done  out  1  high during final active cycle
rf_ra  out  4  register-file read address (STM)
rf_wa  out  4  register-file write address
rf_we  out  1  register-file write enable
rf_wd  out  32  register-file write data
pc_we  out  1  PC load strobe (LDM including R15)
pc_wd  out  32  PC load value
mem_addr  out  32  data memory word address
mem_we  out  1  data memory write enable
mem_wdata  out  32  data memory write data

Behaviour:
- Clock and reset: single clock `clk`. `reset` is asynchronous and active-high.
- Reset state: `reset` forces state IDLE, pending list = 0 and address counter = 0. Every output is 0, including busy, done, all enables, addresses and data. Reset mid-transfer aborts immediately; no further writes occur.
- States: IDLE, XFER, WBASE, EMPTY.
- IDLE, start=1 at posedge:
  - Latch pending = reg_list.
  - Latch n = popcount(reg_list), 5-bit.
  - Latch start address:
    - IA (P=0, U=1): base_val.
    - IB (P=1, U=1): base_val + 4.
    - DA (P=0, U=0): base_val − 4n + 4.
    - DB (P=1, U=0): base_val − 4n.
  - Latch wb_val = U ? base_val + 4n : base_val − 4n (32-bit, wraps modulo 2^32).
  - Latch is_load, w_bit and base_reg.
  - Next state is XFER; if reg_list == 0, next state is EMPTY.
- XFER, one register per cycle:
  - cur = index of lowest set bit of pending.
  - mem_addr = address counter.
  - STM: rf_ra = cur, mem_wdata = rf_rd, mem_we = 1.
  - LDM, cur ≠ 15: rf_wa = cur, rf_wd = mem_rdata, rf_we = 1.
  - LDM, cur = 15: pc_we = 1, pc_wd = mem_rdata, rf_we = 0.
  - Posedge: clear bit cur; address counter += 4.
  - When the last bit is cleared: go to WBASE if (w_bit && !(is_load && base_reg in original list)); otherwise go to IDLE.
- Registers are transferred in ascending order at ascending addresses for all four modes.
- WBASE: rf_wa = base_reg, rf_wd = wb_val, rf_we = 1 for one cycle, then IDLE.
- EMPTY: one cycle, no memory or register writes, then IDLE.
- Base writeback and LDM: base writeback is suppressed when an LDM loads the base register; the loaded value wins.
- STM including base: the value stored is the original Rn, because the register file is not written during an STM transfer.
- busy = (state ≠ IDLE). done = 1 in the last XFER cycle when no WBASE follows, in the WBASE cycle, or in the EMPTY cycle.
- Latency: n cycles of XFER plus 1 cycle if WBASE; EMPTY = 1 cycle.
- Register-file timing: the register file writes on negedge, so a WBASE write is visible to a consumer reading in the following cycle.
- Outputs rf_ra, rf_wa and mem_addr hold 0 when their enables are low.

Decomposition:
- Shared package arm_pkg:
  - seq_state_t enum {IDLE, XFER, WBASE, EMPTY}.
  - Constant PC_IDX = 4'd15.
  - Constant WORD_BYTES = 4.
  - addr_mode_t enum {IA, IB, DA, DB}.
- Sub-module lowest_set16: combinational 16-bit priority encoder, 16-bit in, 4-bit index plus `any` flag. The same instance also feeds the "last bit" detection (pending with cur cleared == 0).

Test Plan:
- STM IA, base_val=0x100, reg_list=0x000E, W=1, Rn=R0:
  - XFER cycles 1–3: rf_ra = 1, 2, 3; mem_addr = 0x100, 0x104, 0x108; mem_we = 1.
  - Cycle 4: rf_we = 1, rf_wa = 0, rf_wd = 0x10C.
  - done = 1 in cycle 4.
- LDM DB, base_val=0x200, reg_list=0x8003, W=0:
  - mem_addr = 0x1F4, 0x1F8, 0x1FC.
  - R0 and R1 are written via rf_we.
  - Third beat: pc_we = 1, pc_wd = mem_rdata, rf_we = 0.
  - busy is high for 3 cycles; no WBASE.
- LDM IB, Rn=R2, base_val=0x40, reg_list=0x0004, W=1:
  - One XFER: mem_addr = 0x44, R2 ← mem_rdata.
  - No WBASE; done = 1 in that cycle.
- reg_list=0, start=1: one EMPTY cycle with busy = 1 and done = 1; mem_we = rf_we = pc_we = 0 throughout.
- start pulsed again during XFER: ignored; the sequence and addresses are unchanged.
- Reset: assert reset mid-XFER of a 4-register STM, between clock edges:
  - All outputs go to 0 immediately, with no later mem_we.
  - After release, a new start runs normally from IDLE.
